// File: rtl/sha_ctrl_pkg.sv
// Shared constants and state encoding for the SHA-256 compression sequencer.
package sha_ctrl_pkg;

  localparam int unsigned ROUNDS = 64;
  localparam int unsigned RIDX_W = $clog2(ROUNDS);
  localparam int unsigned BLK_W  = 2;
  localparam int unsigned WORD_S = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_H = 3'd1,
    INIT   = 3'd2,
    ROUND  = 3'd3,
    FINAL  = 3'd4,
    WAIT_H = 3'd5,
    DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/sha_ctrl_if.sv
// Job/handshake bundle between the sequencer and the hash datapath/host.
interface sha_ctrl_if;
  import sha_ctrl_pkg::*;

  logic              start;
  logic [BLK_W-1:0]  nblk;
  logic              abort;
  logic              msg_valid;
  logic              hash_done;
  logic              en_H;
  logic              en_init;
  logic              en_round;
  logic [RIDX_W-1:0] round_idx;
  logic              en_regs;
  logic [BLK_W-1:0]  blk_idx;
  logic              msg_req;
  logic              busy;
  logic              done;

  // Sequencer side: consumes job/handshake inputs, drives datapath enables.
  modport master (
    input  start, nblk, abort, msg_valid, hash_done,
    output en_H, en_init, en_round, round_idx, en_regs, blk_idx, msg_req, busy, done
  );

  // Host/datapath side.
  modport slave (
    output start, nblk, abort, msg_valid, hash_done,
    input  en_H, en_init, en_round, round_idx, en_regs, blk_idx, msg_req, busy, done
  );

endinterface

// File: rtl/sha_ctrl.sv
// Sequencer for one to three chained SHA-256 block compressions per start.
module sha_ctrl
  import sha_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  sha_ctrl_if.master bus
);

  state_t            state, state_nxt;
  logic [RIDX_W-1:0] round_q, round_nxt;
  logic [BLK_W-1:0]  blk_q, blk_nxt;
  logic [BLK_W-1:0]  nblk_q, nblk_nxt;
  logic              en_h_q, msg_req_q, en_round_q, en_regs_q, busy_q, done_q;

  // Next-state, round counter and block counter decode.
  always_comb begin
    state_nxt = state;
    round_nxt = round_q;
    blk_nxt   = blk_q;
    nblk_nxt  = nblk_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = LOAD_H;
          nblk_nxt  = (bus.nblk == '0) ? BLK_W'(1) : bus.nblk;
          blk_nxt   = '0;
        end
      end
      LOAD_H: state_nxt = INIT;
      INIT: begin
        if (bus.msg_valid) begin
          state_nxt = ROUND;
          round_nxt = '0;
        end
      end
      ROUND: begin
        if (round_q == RIDX_W'(ROUNDS - 1)) begin
          state_nxt = FINAL;
          round_nxt = '0;
        end else begin
          round_nxt = RIDX_W'(round_q + RIDX_W'(1));
        end
      end
      FINAL: state_nxt = WAIT_H;
      WAIT_H: begin
        if (bus.hash_done) begin
          // Chain into the next block without reloading H.
          if ((3'(blk_q) + 3'd1) < 3'(nblk_q)) begin
            blk_nxt   = BLK_W'(blk_q + BLK_W'(1));
            state_nxt = INIT;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every transition, including a coincident hash_done.
    if (bus.abort && (state != IDLE)) begin
      state_nxt = IDLE;
      round_nxt = '0;
    end
  end

  // State/counters plus outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      round_q    <= '0;
      blk_q      <= '0;
      nblk_q     <= BLK_W'(1);
      en_h_q     <= 1'b0;
      msg_req_q  <= 1'b0;
      en_round_q <= 1'b0;
      en_regs_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      round_q    <= round_nxt;
      blk_q      <= blk_nxt;
      nblk_q     <= nblk_nxt;
      en_h_q     <= (state_nxt == LOAD_H);
      msg_req_q  <= (state_nxt == INIT);
      en_round_q <= (state_nxt == ROUND);
      en_regs_q  <= (state_nxt == FINAL);
      busy_q     <= (state_nxt != IDLE);
      done_q     <= (state_nxt == DONE);
    end
  end

  assign bus.en_H      = en_h_q;
  assign bus.msg_req   = msg_req_q;
  assign bus.en_round  = en_round_q;
  assign bus.round_idx = round_q;
  assign bus.en_regs   = en_regs_q;
  assign bus.blk_idx   = blk_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  // Message load fires in the very cycle the words are presented.
  assign bus.en_init   = (state == INIT) & bus.msg_valid;

endmodule

// File: tb/tb_sha_ctrl.sv
// Self-checking bench for sha_ctrl: job-progress model plus cycle-count pins.
module tb_sha_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sha_ctrl_if bus();

  sha_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: job position as a step count within a block.
  // -1 = load H, 0 = waiting for message, 1..64 = rounds, 65 = final add, 66 = waiting for ack.
  bit m_act = 1'b0;
  bit m_fin = 1'b0;
  int m_step = 99;
  int m_blk = 0;
  int m_nblk = 1;
  int jc = 0;

  // Observation statistics for the current job.
  int n_h, h_cyc, n_init, n_round, n_regs, regs_cyc, n_done, done_cyc;
  int init_cyc [4];
  int init_blk [4];
  bit seq_ok;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    n_h = 0; h_cyc = -1; n_init = 0; n_round = 0; n_regs = 0; regs_cyc = -1;
    n_done = 0; done_cyc = -1; seq_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      init_cyc[i] = -1;
      init_blk[i] = -1;
    end
  endtask

  // Advance the job model on each edge; reset clears it at once.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 1'b0; m_fin = 1'b0; m_step = 99; m_blk = 0; m_nblk = 1; jc = 0;
    end else begin
      jc++;
      if (!m_act) begin
        if (bus.start) begin
          m_act = 1'b1; m_fin = 1'b0; m_step = -1; m_blk = 0; jc = 0;
          m_nblk = (bus.nblk == 2'd0) ? 1 : int'(bus.nblk);
        end
      end else if (m_fin || bus.abort) begin
        m_act = 1'b0; m_fin = 1'b0; m_step = 99;
      end else begin
        case (m_step)
          -1: m_step = 0;
          0:  if (bus.msg_valid) m_step = 1;
          66: begin
            if (bus.hash_done) begin
              if (m_blk + 1 < m_nblk) begin
                m_blk++;
                m_step = 0;
              end else begin
                m_fin = 1'b1;
              end
            end
          end
          default: m_step++;
        endcase
      end
    end
  end

  task automatic check_all();
    bit rnd_on;
    rnd_on = m_act && !m_fin && (m_step >= 1) && (m_step <= 64);
    cmp("busy",      bus.busy,      m_act);
    cmp("en_H",      bus.en_H,      m_act && !m_fin && m_step == -1);
    cmp("msg_req",   bus.msg_req,   m_act && !m_fin && m_step == 0);
    cmp("en_init",   bus.en_init,   m_act && !m_fin && m_step == 0 && bus.msg_valid);
    cmp("en_round",  bus.en_round,  rnd_on);
    cmp("round_idx", bus.round_idx, rnd_on ? m_step - 1 : 0);
    cmp("en_regs",   bus.en_regs,   m_act && !m_fin && m_step == 65);
    cmp("done",      bus.done,      m_act && m_fin);
    cmp("blk_idx",   bus.blk_idx,   m_blk);
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int cyc;
    #1;
    check_all();
    cyc = jc + 1;
    if (bus.en_H === 1'b1) begin n_h++; h_cyc = cyc; end
    if (bus.en_init === 1'b1) begin
      if (n_init < 4) begin init_cyc[n_init] = cyc; init_blk[n_init] = int'(bus.blk_idx); end
      n_init++;
    end
    if (bus.en_round === 1'b1) begin
      if (int'(bus.round_idx) != (n_round % 64)) seq_ok = 1'b0;
      n_round++;
    end
    if (bus.en_regs === 1'b1) begin n_regs++; regs_cyc = cyc; end
    if (bus.done === 1'b1) begin n_done++; done_cyc = cyc; end
  end

  task automatic check_zero(input string tag);
    cmp({tag, "_busy"},  bus.busy, 0);
    cmp({tag, "_en_H"},  bus.en_H, 0);
    cmp({tag, "_req"},   bus.msg_req, 0);
    cmp({tag, "_init"},  bus.en_init, 0);
    cmp({tag, "_round"}, bus.en_round, 0);
    cmp({tag, "_ridx"},  bus.round_idx, 0);
    cmp({tag, "_regs"},  bus.en_regs, 0);
    cmp({tag, "_done"},  bus.done, 0);
    cmp({tag, "_blk"},   bus.blk_idx, 0);
  endtask

  // Drive one job; stall/delay/abort/glitch points are keyed on the model's step.
  task automatic run_job(input int nb, input int mv_stall, input int hd_delay,
                         input int abort_rnd, input int busy_start_step,
                         input int hd_glitch_step, input int reset_step, input bit rnd);
    int icnt, wcnt, k;
    clear_stats();
    @(negedge clk);
    bus.start = 1'b1; bus.nblk = 2'(nb); bus.abort = 1'b0;
    bus.msg_valid = 1'b0; bus.hash_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    icnt = 0; wcnt = 0; k = 0;
    while (m_act && k < 3000) begin
      if (rnd) begin
        bus.start     = ($urandom_range(0, 15) == 0);
        bus.nblk      = 2'($urandom_range(0, 3));
        bus.msg_valid = ($urandom_range(0, 1) == 1);
        bus.hash_done = ($urandom_range(0, 3) == 0);
        bus.abort     = ($urandom_range(0, 199) == 0);
      end else begin
        bus.start     = (m_step == busy_start_step);
        bus.msg_valid = !(m_step == 0 && icnt < mv_stall);
        bus.hash_done = (m_step == 66 && wcnt >= hd_delay) || (m_step == hd_glitch_step);
        bus.abort     = (abort_rnd >= 0) && (m_step == abort_rnd + 1);
      end
      icnt = (m_step == 0) ? icnt + 1 : 0;
      wcnt = (m_step == 66) ? wcnt + 1 : 0;
      if (m_step == reset_step) begin
        #2 reset = 1'b1;
        #1 check_zero("async_rst");
        #1 reset = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.msg_valid = 1'b0; bus.hash_done = 1'b0;
    if (m_act) begin
      vectors++; miscompares++;
      $display("FAIL job_timeout: job still active after %0d cycles at %0t", k, $time);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  localparam int NONE = -100;

  initial begin
    bus.start = 1'b0; bus.nblk = 2'd0; bus.abort = 1'b0;
    bus.msg_valid = 1'b0; bus.hash_done = 1'b0;
    clear_stats();
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single block, no stalls.
    run_job(1, 0, 0, NONE, NONE, NONE, NONE, 1'b0);
    cmp("s1_nH", n_h, 1);        cmp("s1_H_cyc", h_cyc, 1);
    cmp("s1_init_cyc", init_cyc[0], 2);
    cmp("s1_nround", n_round, 64); cmp("s1_round_seq", seq_ok, 1);
    cmp("s1_regs_cyc", regs_cyc, 67);
    cmp("s1_ndone", n_done, 1);  cmp("s1_done_cyc", done_cyc, 69);

    // Two chained blocks.
    run_job(2, 0, 0, NONE, NONE, NONE, NONE, 1'b0);
    cmp("s2_nH", n_h, 1);
    cmp("s2_init0_cyc", init_cyc[0], 2);  cmp("s2_init0_blk", init_blk[0], 0);
    cmp("s2_init1_cyc", init_cyc[1], 69); cmp("s2_init1_blk", init_blk[1], 1);
    cmp("s2_done_cyc", done_cyc, 136);    cmp("s2_final_blk", bus.blk_idx, 1);

    // Three blocks.
    run_job(3, 0, 0, NONE, NONE, NONE, NONE, 1'b0);
    cmp("s3_ninit", n_init, 3); cmp("s3_done_cyc", done_cyc, 203);

    // Message stall of 5 cycles and hash ack 3 cycles late.
    run_job(1, 5, 3, NONE, NONE, NONE, NONE, 1'b0);
    cmp("st_init_cyc", init_cyc[0], 7); cmp("st_done_cyc", done_cyc, 77);
    cmp("st_round_seq", seq_ok, 1);

    // Abort at round 30, then a clean run.
    run_job(1, 0, 0, 30, NONE, NONE, NONE, 1'b0);
    cmp("ab_ndone", n_done, 0); cmp("ab_nregs", n_regs, 0);
    cmp("ab_nround", n_round, 31); cmp("ab_busy", bus.busy, 0);
    run_job(1, 0, 0, NONE, NONE, NONE, NONE, 1'b0);
    cmp("ab_rerun_done_cyc", done_cyc, 69);

    // Asynchronous reset mid-round.
    run_job(2, 0, 0, NONE, NONE, NONE, 20, 1'b0);
    cmp("rs_ndone", n_done, 0);

    // nblk=0 acts as 1; start while busy and hash_done during rounds are ignored.
    run_job(0, 0, 0, NONE, 10, 12, NONE, 1'b0);
    cmp("edge_ninit", n_init, 1); cmp("edge_done_cyc", done_cyc, 69);
    cmp("edge_ndone", n_done, 1);

    // Randomized jobs.
    for (int j = 0; j < 40; j++)
      run_job(int'($urandom_range(0, 3)), 0, 0, NONE, NONE, NONE, NONE, 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
